// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder: FSM state encoding,
// default word width and the fixed mode-0 clock polarity/phase.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } spi_resp_state_t;

    localparam int SPI_DATA_W = 8;
    localparam bit SPI_CPOL   = 1'b0;
    localparam bit SPI_CPHA   = 1'b0;

endpackage

// File: rtl/spi_responder_if.sv
// Byte-level client bus of the SPI responder: TX holding-register handshake
// plus received-word, underrun and busy status.
interface spi_responder_if
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W
) ();

    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              tx_underrun;
    logic              busy;

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, rx_data, rx_valid, tx_underrun, busy
    );

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, rx_data, rx_valid, tx_underrun, busy
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin followed by an edge
// register, giving the synchronized level and single-cycle rise/fall strobes.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int STAGES    = 2,
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 responder running entirely in the clk domain: oversampled
// cs/sclk/mosi, one-entry TX holding register, MSB-first shift registers.
module spi_responder
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cs,
    input  logic            sclk,
    input  logic            mosi,
    output logic            miso,
    spi_responder_if.slave  bus
);

    localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic cs_level, cs_rise, cs_fall;
    logic sclk_level_unused, sclk_rise, sclk_fall;

    // cs idles high, so its chain resets high to avoid a false select after reset
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (cs),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(SPI_CPOL)) u_sclk_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (sclk),
        .level (sclk_level_unused),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    // Same depth as the sclk chain so mosi is sampled at the matching instant
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   mosi_s;

    spi_resp_state_t   state_q, state_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rx_valid_q, rx_valid_d;
    logic              tx_underrun_q, tx_underrun_d;
    logic              miso_q, miso_d;
    logic              busy_q, busy_d;
    logic              load_tx;
    logic              accept;

    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign accept = bus.tx_valid && !hold_full_q;

    always_comb begin
        mosi_sync_d   = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        state_d       = state_q;
        tx_shift_d    = tx_shift_q;
        rx_shift_d    = rx_shift_q;
        rx_data_d     = rx_data_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        cnt_d         = cnt_q;
        rx_valid_d    = 1'b0;
        tx_underrun_d = 1'b0;
        load_tx       = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (cs_fall) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                load_tx = 1'b1;
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
                    if (cnt_q == LAST_BIT) begin
                        rx_data_d  = {rx_shift_q[DATA_W-2:0], mosi_s};
                        rx_valid_d = 1'b1;
                        cnt_d      = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                // A fall with the counter at zero can only follow a completed word
                if (sclk_fall) begin
                    if (cnt_q == '0) begin
                        load_tx = !cs_level;
                    end else begin
                        tx_shift_d = tx_shift_q << 1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (cs_rise) begin
            state_d    = IDLE;
            cnt_d      = '0;
            rx_valid_d = 1'b0;
            rx_data_d  = rx_data_q;
            load_tx    = 1'b0;
        end

        if (load_tx) begin
            if (hold_full_q) begin
                tx_shift_d = hold_q;
            end else begin
                tx_shift_d    = '0;
                tx_underrun_d = 1'b1;
            end
        end

        if (accept) begin
            hold_d      = bus.tx_data;
            hold_full_d = 1'b1;
        end else if (load_tx && hold_full_q) begin
            hold_full_d = 1'b0;
        end

        miso_d = (state_d == SHIFT) ? tx_shift_d[DATA_W-1] : 1'b0;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mosi_sync_q   <= '0;
            state_q       <= IDLE;
            tx_shift_q    <= '0;
            rx_shift_q    <= '0;
            rx_data_q     <= '0;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            cnt_q         <= '0;
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            miso_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            mosi_sync_q   <= mosi_sync_d;
            state_q       <= state_d;
            tx_shift_q    <= tx_shift_d;
            rx_shift_q    <= rx_shift_d;
            rx_data_q     <= rx_data_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            cnt_q         <= cnt_d;
            rx_valid_q    <= rx_valid_d;
            tx_underrun_q <= tx_underrun_d;
            miso_q        <= miso_d;
            busy_q        <= busy_d;
        end
    end

    assign miso            = miso_q;
    assign bus.tx_ready    = !hold_full_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_underrun = tx_underrun_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_spi_responder.sv
// Bench for spi_responder: an SPI mode-0 master task plus a TX client, checked
// against a word-level model of what the master and the client should observe.
module tb_spi_responder;
    import spi_pkg::*;

    localparam int W = 8;
    localparam int S = 2;

    logic clk  = 1'b0;
    logic rst  = 1'b0;
    logic cs   = 1'b1;
    logic sclk = 1'b0;
    logic mosi = 1'b0;
    logic miso;

    spi_responder_if #(.DATA_W(W)) bus ();

    spi_responder #(.DATA_W(W), .SYNC_STAGES(S)) dut (
        .clk  (clk),
        .rst  (rst),
        .cs   (cs),
        .sclk (sclk),
        .mosi (mosi),
        .miso (miso),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int half   = 5;

    logic [W-1:0] m_tx[$];
    logic [W-1:0] m_rx[$];
    logic [W-1:0] exp_tx[$];
    logic [W-1:0] rx_seen[$];
    logic [W-1:0] last_rx = '0;
    int und_seen  = 0;
    int und_exp   = 0;
    int width_err = 0;
    logic rv_prev = 1'b0;
    logic un_prev = 1'b0;

    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) rx_seen.push_back(bus.rx_data);
        if (bus.tx_underrun === 1'b1) und_seen <= und_seen + 1;
        if ((bus.rx_valid === 1'b1 && rv_prev === 1'b1) ||
            (bus.tx_underrun === 1'b1 && un_prev === 1'b1))
            width_err <= width_err + 1;
        rv_prev <= bus.rx_valid;
        un_prev <= bus.tx_underrun;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_words(input int n, input logic [W-1:0] a, input logic [W-1:0] b);
        m_tx.delete();
        m_tx.push_back(a);
        if (n > 1) m_tx.push_back(b);
    endtask

    // Client side: hold tx_valid until the holding register accepts the word
    task automatic push_tx(input logic [W-1:0] d);
        bit ok = 1'b0;
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (bus.tx_ready === 1'b1) ok = 1'b1;
        end
        chk("tx_accept_timeout", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        bus.tx_valid = 1'b0;
        if (ok) exp_tx.push_back(d);
        @(negedge clk);
        chk("tx_ready_fall", 32'(bus.tx_ready), 32'd0);
    endtask

    // One mode-0 bit; the final fall of a frame coincides with cs rising
    task automatic spi_bit(input logic mo, input bit last, output logic mi);
        mosi = mo;
        wait_clks(half);
        mi   = miso;
        sclk = 1'b1;
        wait_clks(half);
        sclk = 1'b0;
        if (last) begin
            cs   = 1'b1;
            mosi = 1'b0;
        end
    endtask

    task automatic frame(input int nbits);
        logic [W-1:0] cap = '0;
        logic [W-1:0] word;
        logic         b;
        m_rx.delete();
        cs = 1'b0;
        wait_clks(1);
        for (int i = 0; i < nbits; i++) begin
            word = m_tx[i / W];
            spi_bit(word[W-1-(i % W)], (i == nbits - 1), b);
            cap = {cap[W-2:0], b};
            if ((i % W) == W - 1) m_rx.push_back(cap);
        end
        wait_clks(8);
    endtask

    task automatic check_frame(input int nwords, input string tag);
        logic [W-1:0] e;
        chk({tag, "_rx_count"}, 32'(rx_seen.size()), 32'(nwords));
        for (int i = 0; i < nwords; i++) begin
            if (exp_tx.size() > 0) begin
                e = exp_tx.pop_front();
            end else begin
                e = '0;
                und_exp++;
            end
            chk({tag, "_miso_word"}, 32'(m_rx[i]), 32'(e));
            if (rx_seen.size() > 0) chk({tag, "_rx_word"}, 32'(rx_seen.pop_front()), 32'(m_tx[i]));
            last_rx = m_tx[i];
        end
        chk({tag, "_underruns"}, 32'(und_seen), 32'(und_exp));
        chk({tag, "_pulse_width"}, 32'(width_err), 32'd0);
        chk({tag, "_rx_data"}, 32'(bus.rx_data), 32'(last_rx));
        chk({tag, "_busy_idle"}, 32'(bus.busy), 32'd0);
        chk({tag, "_miso_idle"}, 32'(miso), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_miso"}, 32'(miso), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_tx_ready"}, 32'(bus.tx_ready), 32'd1);
        chk({tag, "_rx_valid"}, 32'(bus.rx_valid), 32'd0);
        chk({tag, "_tx_underrun"}, 32'(bus.tx_underrun), 32'd0);
        chk({tag, "_rx_data"}, 32'(bus.rx_data), 32'd0);
    endtask

    initial begin
        logic b;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        wait_clks(5);

        push_tx(8'h3C);
        set_words(1, 8'hA5, 8'h00);
        frame(W);
        check_frame(1, "single");

        push_tx(8'h11);
        set_words(2, 8'hF0, 8'h0F);
        fork
            frame(2 * W);
            push_tx(8'h22);
        join
        check_frame(2, "b2b");

        set_words(1, 8'h96, 8'h00);
        frame(5);
        if (exp_tx.size() > 0) void'(exp_tx.pop_front());
        else und_exp++;
        chk("abort_rx_count", 32'(rx_seen.size()), 32'd0);
        chk("abort_rx_data", 32'(bus.rx_data), 32'(last_rx));
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_underruns", 32'(und_seen), 32'(und_exp));
        push_tx(8'hE7);
        set_words(1, 8'h6B, 8'h00);
        frame(W);
        check_frame(1, "after_abort");

        set_words(1, 8'h5A, 8'h00);
        frame(W);
        check_frame(1, "underrun");

        push_tx(8'hAB);
        bus.tx_data  = 8'hCD;
        bus.tx_valid = 1'b1;
        wait_clks(10);
        chk("hold_ready_low", 32'(bus.tx_ready), 32'd0);
        set_words(1, 8'h24, 8'h00);
        fork
            frame(W);
            push_tx(8'hCD);
        join
        check_frame(1, "hold_first");
        set_words(1, 8'h81, 8'h00);
        frame(W);
        check_frame(1, "hold_second");

        push_tx(8'h77);
        set_words(1, 8'h3E, 8'h00);
        cs = 1'b0;
        wait_clks(1);
        for (int i = 0; i < 3; i++) spi_bit(m_tx[0][W-1-i], 1'b0, b);
        rst = 1'b0;
        #1;
        check_reset_outputs("midword_reset");
        cs   = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        exp_tx.delete();
        last_rx = '0;
        wait_clks(3);
        rst = 1'b1;
        wait_clks(5);
        set_words(1, 8'hC3, 8'h00);
        frame(W);
        check_frame(1, "post_reset");

        for (int k = 0; k < 6; k++) begin
            half = int'($urandom_range(5, 7));
            if ($urandom_range(0, 1) == 1) push_tx(W'($urandom));
            set_words(1, W'($urandom), 8'h00);
            frame(W);
            check_frame(1, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
